// File: rtl/vga_controle.sv
// vga_controle: 640x480@60 Hz VGA raster generator for a DAC clocked at
// half of CLOCK_50. Publishes the raster coordinate to the renderer, samples
// the renderer's registered colour one pixel later and drives sync, blank and
// colour pixel-aligned. Also emits a one-cycle frame tick at each frame start.
module vga_controle #(
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic [9:0] VGA_X,
    output logic [9:0] VGA_Y,
    input  logic [7:0] cor_r,
    input  logic [7:0] cor_g,
    input  logic [7:0] cor_b,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_tick
);

    // Derived raster geometry, all expressed in the 10-bit counter domain.
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);

    // Pixel-clock phase: the DAC clock is this register, and the pixel
    // enable is its value before the edge, so every output update lands one
    // CLOCK_50 cycle ahead of the DAC's rising edge.
    logic       phase;
    logic       pix_en;

    // Raster counters and their next values.
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;

    // Output-stage inputs decoded from the counters in force before the edge.
    logic       hs_d;
    logic       vs_d;
    logic       vis_d;
    logic       h_vis;
    logic       v_vis;
    logic [7:0] r_d;
    logic [7:0] g_d;
    logic [7:0] b_d;

    assign pix_en = phase;

    // Toggle the pixel-clock phase on every CLOCK_50 edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    // Counter wrap detection and next values; the >= tests keep the counters
    // inside their ranges even if a corrupted value ever appeared.
    always_comb begin
        h_wrap     = (h >= H_LAST);
        v_wrap     = (v >= V_LAST);
        frame_wrap = h_wrap && v_wrap;

        if (h_wrap) begin
            h_next = 10'd0;
        end else begin
            h_next = h + 10'd1;
        end

        if (!h_wrap) begin
            v_next = v;
        end else if (v_wrap) begin
            v_next = 10'd0;
        end else begin
            v_next = v + 10'd1;
        end
    end

    // Advance the raster counters once per pixel.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (pix_en) begin
            h <= h_next;
            v <= v_next;
        end else begin
            h <= h;
            v <= v;
        end
    end

    // Decode sync and visibility for the current coordinate and gate colour
    // to black outside the visible window.
    always_comb begin
        hs_d  = (h >= H_SYNC_END);
        vs_d  = (v >= V_SYNC_END);
        h_vis = (h >= H_VIS_START) && (h < H_VIS_END);
        v_vis = (v >= V_VIS_START) && (v < V_VIS_END);
        vis_d = h_vis && v_vis;

        if (vis_d) begin
            r_d = cor_r;
            g_d = cor_g;
            b_d = cor_b;
        end else begin
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
        end
    end

    // Register sync, blank and colour together so they stay pixel-aligned;
    // the renderer's colour for the previous coordinate arrives here.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else if (pix_en) begin
            VGA_HS      <= hs_d;
            VGA_VS      <= vs_d;
            VGA_BLANK_N <= vis_d;
            VGA_R       <= r_d;
            VGA_G       <= g_d;
            VGA_B       <= b_d;
        end else begin
            VGA_HS      <= VGA_HS;
            VGA_VS      <= VGA_VS;
            VGA_BLANK_N <= VGA_BLANK_N;
            VGA_R       <= VGA_R;
            VGA_G       <= VGA_G;
            VGA_B       <= VGA_B;
        end
    end

    // Pulse the frame tick for the single CLOCK_50 cycle after both counters
    // wrap; the following edge is never a pixel enable, so it clears itself.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && frame_wrap;
        end
    end

    assign VGA_X      = h;
    assign VGA_Y      = v;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_controle.sv
// Bench for vga_controle: a full-size instance and a shrunken-raster instance
// share clock, reset and colour inputs. Every cycle both are compared against
// an arithmetic raster model driven by the count of edges since reset.
module tb_vga_controle;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync_n;
        logic       clk;
        logic       tick;
    } out_t;

    typedef struct {
        int         n;
        logic       align;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       clk;
        logic [7:0] r;
    } vec_t;

    logic        CLOCK_50;
    logic        reset;
    logic [7:0]  cor_r;
    logic [7:0]  cor_g;
    logic [7:0]  cor_b;
    logic [23:0] rnd;
    logic [7:0]  ren_r;
    logic        align;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic a_hs, a_vs, a_blank, a_sync, a_clk, a_tick;
    logic b_hs, b_vs, b_blank, b_sync, b_clk, b_tick;

    int          n;
    logic [23:0] col_cap;
    int          total;
    int          bad;
    logic        chk_en;
    int          hs_low_a, vs_low_b, blank_b, tick_b, tick_early;

    vga_controle dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .VGA_X(a_x), .VGA_Y(a_y),
        .cor_r(cor_r), .cor_g(cor_g), .cor_b(cor_b),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync), .VGA_CLK(a_clk),
        .frame_tick(a_tick)
    );

    vga_controle #(
        .H_SYNC(4), .H_BACK(3), .H_VISIBLE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VISIBLE(5), .V_FRONT(1)
    ) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .VGA_X(b_x), .VGA_Y(b_y),
        .cor_r(cor_r), .cor_g(cor_g), .cor_b(cor_b),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync), .VGA_CLK(b_clk),
        .frame_tick(b_tick)
    );

    assign cor_r = align ? ren_r : rnd[23:16];
    assign cor_g = rnd[15:8];
    assign cor_b = rnd[7:0];

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Random colour changes just after each active edge.
    initial begin
        rnd = 24'd0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            rnd = 24'($urandom);
        end
    end

    // Renderer stand-in: registers the low byte of the published X.
    always @(posedge CLOCK_50) ren_r <= a_x[7:0];

    // Edge counter since reset and the colour seen at each pixel-enable edge.
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            n       <= 0;
            col_cap <= 24'd0;
        end else begin
            if (n % 2 == 1) col_cap <= {cor_r, cor_g, cor_b};
            n <= n + 1;
        end
    end

    // Raster state after n edges since reset: pixel k = n/2 is being
    // published, pixel k-1 is on the DAC.
    function automatic out_t model(input int nn, input int ht, input int hsw,
                                   input int hbk, input int hvi, input int vt,
                                   input int vsw, input int vbk, input int vvi,
                                   input logic [23:0] col);
        out_t o;
        int   k, q, hp, vp;
        logic vis;
        k        = nn / 2;
        o.x      = 10'(k % ht);
        o.y      = 10'((k / ht) % vt);
        o.clk    = (nn % 2 == 1);
        o.sync_n = 1'b0;
        o.tick   = (nn > 0) && (nn % 2 == 0) && (k % (ht * vt) == 0);
        if (k == 0) begin
            o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0;
            o.r = 8'd0; o.g = 8'd0; o.b = 8'd0;
        end else begin
            q   = k - 1;
            hp  = q % ht;
            vp  = (q / ht) % vt;
            vis = (hp >= hsw + hbk) && (hp < hsw + hbk + hvi) &&
                  (vp >= vsw + vbk) && (vp < vsw + vbk + vvi);
            o.hs    = (hp >= hsw);
            o.vs    = (vp >= vsw);
            o.blank = vis;
            o.r = vis ? col[23:16] : 8'd0;
            o.g = vis ? col[15:8]  : 8'd0;
            o.b = vis ? col[7:0]   : 8'd0;
        end
        return o;
    endfunction

    task automatic cycle_check();
        out_t ea, eb, aa, ab;
        int   q;
        if (chk_en) begin
            ea = model(n, 800, 96, 48, 640, 525, 2, 33, 480, col_cap);
            eb = model(n, 17, 4, 3, 8, 10, 2, 2, 5, col_cap);
            aa = {a_x, a_y, a_r, a_g, a_b, a_hs, a_vs, a_blank, a_sync, a_clk, a_tick};
            ab = {b_x, b_y, b_r, b_g, b_b, b_hs, b_vs, b_blank, b_sync, b_clk, b_tick};
            total++;
            if (aa !== ea) begin
                bad++;
                $display("FAIL model_full n=%0d got=%h exp=%h", n, aa, ea);
            end
            total++;
            if (ab !== eb) begin
                bad++;
                $display("FAIL model_small n=%0d got=%h exp=%h", n, ab, eb);
            end
            if (align && ea.blank) begin
                q = n / 2 - 1;
                total++;
                if (a_r !== 8'((q % 800) % 256)) begin
                    bad++;
                    $display("FAIL align n=%0d got=%0d exp=%0d", n, a_r, (q % 800) % 256);
                end
            end
            if ((reset || n <= 20) && (b_tick === 1'b1 || a_tick === 1'b1)) tick_early++;
            if (reset) begin
                hs_low_a = 0; vs_low_b = 0; blank_b = 0; tick_b = 0;
            end else begin
                if (n >= 2 && n <= 1601 && a_hs === 1'b0) hs_low_a++;
                if (n >= 2 && n <= 341 && b_vs === 1'b0) vs_low_b++;
                if (n >= 2 && n <= 341 && b_blank === 1'b1) blank_b++;
                if (n >= 1 && n <= 1021 && b_tick === 1'b1) tick_b++;
            end
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        cycle_check();
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    vec_t tv[15];

    initial begin
        int guard;
        logic [46:0] got_v, exp_v;

        // n, align, x, y, hs, vs, blank, clk, r  (full-size instance)
        tv[0]  = '{0,     1'b0, 10'd0,   10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[1]  = '{1,     1'b0, 10'd0,   10'd0,  1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        tv[2]  = '{2,     1'b0, 10'd1,   10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[3]  = '{3,     1'b0, 10'd1,   10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tv[4]  = '{193,   1'b0, 10'd96,  10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tv[5]  = '{194,   1'b0, 10'd97,  10'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[6]  = '{1600,  1'b0, 10'd0,   10'd1,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[7]  = '{1602,  1'b0, 10'd1,   10'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tv[8]  = '{3202,  1'b0, 10'd1,   10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[9]  = '{3204,  1'b0, 10'd2,   10'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[10] = '{56288, 1'b1, 10'd144, 10'd35, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[11] = '{56290, 1'b1, 10'd145, 10'd35, 1'b1, 1'b1, 1'b1, 1'b0, 8'd144};
        tv[12] = '{57568, 1'b1, 10'd784, 10'd35, 1'b1, 1'b1, 1'b1, 1'b0, 8'd15};
        tv[13] = '{57570, 1'b1, 10'd785, 10'd35, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tv[14] = '{57600, 1'b1, 10'd0,   10'd36, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

        total = 0; bad = 0; chk_en = 1'b0; align = 1'b0;
        hs_low_a = 0; vs_low_b = 0; blank_b = 0; tick_b = 0; tick_early = 0;
        reset = 1'b1;

        // Power-up reset, then run into the middle of a frame.
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) step();

        // Reset mid-frame, hold, release.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;

        // Boundary vectors for the full-size raster.
        for (int i = 0; i < 15; i++) begin
            align = tv[i].align;
            guard = 0;
            while (n != tv[i].n && guard < 70000) begin
                step();
                guard++;
            end
            exp_v = {tv[i].x, tv[i].y, tv[i].hs, tv[i].vs, tv[i].blank, tv[i].clk, tv[i].r};
            got_v = {a_x, a_y, a_hs, a_vs, a_blank, a_clk, a_r};
            total++;
            if (n != tv[i].n || got_v !== exp_v) begin
                bad++;
                $display("FAIL vec%0d n=%0d got=%h exp=%h", i, n, got_v, exp_v);
            end
        end

        // Per-line / per-frame interval counts.
        check_int("hs_low_full", hs_low_a, 192);
        check_int("vs_low_small", vs_low_b, 68);
        check_int("blank_small", blank_b, 80);
        check_int("ticks_small", tick_b, 3);

        // Reset in mid-operation at small-raster position h=10, v=6.
        align = 1'b0;
        guard = 0;
        while (n % 340 != 224 && guard < 1000) begin
            step();
            guard++;
        end
        check_int("midop_reach", n % 340, 224);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        guard = 0;
        while (n < 1100 && guard < 2000) begin
            step();
            guard++;
        end
        check_int("midop_vs_low", vs_low_b, 68);
        check_int("midop_blank", blank_b, 80);
        check_int("midop_ticks", tick_b, 3);
        check_int("hs_low_restart", hs_low_a, 192);
        check_int("no_early_tick", tick_early, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_controle.md
# vga_controle

Generates the 640x480@60 Hz VGA raster from CLOCK_50 and drives the board's VGA DAC. It publishes the current raster coordinate to the pixel renderer on VGA_X/VGA_Y and samples the renderer's registered colour. It then outputs that colour together with HS, VS, BLANK and SYNC, delayed so that sync and colour stay pixel-aligned. It also emits a one-clock frame tick for the game-logic update.

## Interface
Parameters:
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch

Ports:
- CLOCK_50  in  1  50 MHz system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- VGA_X  out  10  horizontal raster counter, 0..799; sync occupies 0..95, visible region is 144..783
- VGA_Y  out  10  vertical raster counter, 0..524; sync occupies 0..1, visible region is 35..514
- cor_r, cor_g, cor_b  in  8 each  renderer colour for the coordinate presented one pixel earlier
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour
- VGA_HS, VGA_VS  out  1  sync outputs, active low
- VGA_BLANK_N  out  1  high only inside the visible region
- VGA_SYNC_N  out  1  tied to 0 (no sync-on-green)
- VGA_CLK  out  1  25 MHz pixel clock to the DAC
- frame_tick  out  1  one-CLOCK_50 pulse at the start of each frame

## Operation
- Phase register p: resets to 0 and toggles every CLOCK_50 cycle. VGA_CLK = p.
- Pixel enable: asserted on CLOCK_50 edges where p == 1 before the edge. All counter and output-stage updates happen only on pixel-enable edges.
- Horizontal counter h: increments each pixel enable. At 799 it wraps to 0 and the vertical counter v increments.
- Vertical counter: at 524 with h = 799, v wraps to 0. H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters.
- VGA_X = h and VGA_Y = v, taken directly from the counter registers.
- Output stage, registered on pixel enable, from the h/v values in force before the edge:
  - hs = (h >= H_SYNC)
  - vs = (v >= V_SYNC)
  - vis = (H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_VISIBLE) and (V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_VISIBLE)
  - VGA_BLANK_N = vis
  - VGA_R/G/B = vis ? cor_* : 0. The colour is forced to 0 during blanking regardless of cor_*.
- frame_tick: high for exactly the one CLOCK_50 cycle following the edge on which h and v both wrap to 0; low otherwise.
- All comparisons are unsigned, 10-bit. The counters must never exceed 799 or 524.

## Timing
- Reset values:
  - h = 0, v = 0, p = 0, VGA_CLK = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0
  - VGA_R/G/B = 0, frame_tick = 0, VGA_SYNC_N = 0
- Reset takes effect immediately, mid-line or mid-frame; nothing is preserved.
- After reset deasserts: first edge sets p to 1; the second edge is the first pixel enable. On that enable h becomes 1 and the output stage samples the state for (0,0).
- Latency: VGA_X/VGA_Y change on a pixel-enable edge. The renderer registers colour on the next CLOCK_50 edge. The output stage captures cor_* and the derived sync/blank on the following pixel-enable edge. The DAC outputs therefore lag the coordinate by exactly 2 CLOCK_50 cycles (one pixel), with sync, blank and colour mutually aligned.
- VGA_CLK rises one CLOCK_50 cycle after each output update, so DAC data is stable across the rising edge.
- Line period is 1600 CLOCK_50 cycles; frame period is 840000 cycles. frame_tick period equals the frame period exactly.

## Test plan
- Reset release: assert reset mid-frame, release. Check all reset values. On the second edge after release, h = 1, v = 0 and VGA_HS = 0 (sampled h = 0).
- Horizontal timing: over one line, VGA_HS is low for exactly 192 CLOCK_50 cycles and the line period is 1600 cycles. VGA_X runs 0..799, then 0, with v incrementing exactly once.
- Vertical timing and tick: over two frames, VGA_VS is low for 3200 cycles per frame. frame_tick pulses exactly once per 840000 cycles, each pulse 1 cycle wide, immediately after h = v = 0.
- Blanking and colour: drive cor_* = 8'hFF constant. VGA_BLANK_N is high exactly 640x480 pixel times per frame. The first visible DAC pixel appears one pixel after VGA_X = 144, VGA_Y = 35. VGA_R = 0 whenever VGA_BLANK_N = 0.
- Alignment: drive cor_r = VGA_X[7:0] through a 1-clock register model of the renderer. At every visible DAC pixel, VGA_R equals the low 8 bits of the coordinate published one pixel earlier.
- Reset mid-operation: assert reset at h = 500, v = 300 for 3 cycles. The restart is identical to the cold-reset case, and no frame_tick occurs during or immediately after reset.
